// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage access unit: op codes, FSM states
// and small classification helpers used by the datapath.
package mau_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd9;
    localparam logic [3:0] OP_SH  = 4'd10;
    localparam logic [3:0] OP_SW  = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a little-endian read word and
// sign- or zero-extends it according to the load op.
module load_align
    import mau_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [3:0]  op,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h000000, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues data-memory accesses over a req/ack handshake, aligns
// load data for writeback, and reports misalignment and bus timeouts.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        addr_err,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t state, state_d;

    logic [3:0]       op_q, op_d;
    logic [31:0]      addr_q, addr_d;
    logic [4:0]       rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        mem_req_d, mem_we_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic [3:0]  mem_be_d;
    logic        wb_valid_d, wb_we_d, addr_err_d, bus_err_d;
    logic [4:0]  wb_rd_d;
    logic [31:0] wb_data_d, err_addr_d;

    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] load_data;

    assign in_ready = (state == IDLE);
    assign stall    = in_valid & ~in_ready;

    // Aligned against the live read bus so wb_data is ready in RESP.
    load_align u_load_align (
        .rdata (mem_rdata),
        .addr  (addr_q[1:0]),
        .op    (op_q),
        .data  (load_data)
    );

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = '0;
        case (in_op)
            OP_SB: begin
                be_new    = 4'b0001 << in_addr[1:0];
                wdata_new = {4{in_wdata[7:0]}};
            end
            OP_SH: begin
                be_new    = in_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{in_wdata[15:0]}};
            end
            OP_SW:   wdata_new = in_wdata;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state;
        op_d        = op_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_be_d    = mem_be;
        mem_wdata_d = mem_wdata;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_rd_d     = '0;
        wb_data_d   = '0;
        addr_err_d  = 1'b0;
        bus_err_d   = 1'b0;
        err_addr_d  = '0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_load(in_op) || is_store(in_op)) begin
                        if (is_misaligned(in_op, in_addr[1:0])) begin
                            addr_err_d = 1'b1;
                            err_addr_d = in_addr;
                        end else begin
                            state_d     = ACCESS;
                            op_d        = in_op;
                            addr_d      = in_addr;
                            rd_d        = in_rd;
                            cnt_d       = '0;
                            mem_req_d   = 1'b1;
                            mem_we_d    = is_store(in_op);
                            mem_addr_d  = {in_addr[31:2], 2'b00};
                            mem_be_d    = be_new;
                            mem_wdata_d = wdata_new;
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = (in_rd != 5'd0);
                        wb_rd_d    = in_rd;
                        wb_data_d  = in_addr;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ack) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                    wb_valid_d  = 1'b1;
                    wb_rd_d     = rd_q;
                    if (is_load(op_q)) begin
                        wb_we_d   = (rd_q != 5'd0);
                        wb_data_d = load_data;
                    end
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                    bus_err_d   = 1'b1;
                    err_addr_d  = addr_q;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            addr_err  <= 1'b0;
            bus_err   <= 1'b0;
            err_addr  <= '0;
        end else begin
            state     <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_be    <= mem_be_d;
            mem_wdata <= mem_wdata_d;
            wb_valid  <= wb_valid_d;
            wb_we     <= wb_we_d;
            wb_rd     <= wb_rd_d;
            wb_data   <= wb_data_d;
            addr_err  <= addr_err_d;
            bus_err   <= bus_err_d;
            err_addr  <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected results,
// a memory responder and an output monitor compare independently.
module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        wb_valid, wb_we, addr_err, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, err_addr;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .addr_err(addr_err), .bus_err(bus_err), .err_addr(err_addr)
    );

    // kind: 4 = writeback, 2 = addr_err, 1 = bus_err
    typedef struct {
        int          kind;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } out_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
        int          len;
        int          wt;
        logic [31:0] rdata;
    } req_exp_t;

    out_exp_t exp_q[$];
    req_exp_t req_q[$];
    int total = 0;
    int bad = 0;
    int last_stalls = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_out(input int kind, input logic we, input logic [4:0] rd, input logic [31:0] data);
        out_exp_t e;
        e.kind = kind; e.we = we; e.rd = rd; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic chk_wdata, input int len,
                            input int wt, input logic [31:0] rdata);
        req_exp_t r;
        r.we = we; r.addr = addr; r.be = be; r.wdata = wdata; r.chk_wdata = chk_wdata;
        r.len = len; r.wt = wt; r.rdata = rdata;
        req_q.push_back(r);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata; in_rd = rd;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                chk("stall_idle", {31'd0, stall}, 32'd0);
                break;
            end
            chk("stall_busy", {31'd0, stall}, 32'd1);
            n++;
            if (n > 40) begin
                total++; bad++;
                $display("FAIL accept_timeout: op=%0d not accepted after %0d cycles", op, n);
                break;
            end
        end
        last_stalls = n;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Memory responder: checks request fields every cycle and the request length.
    initial begin : responder
        int n;
        req_exp_t r;
        n = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                n++;
                if (req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_req: addr=%h expected no request", mem_addr);
                    mem_ack = 1'b0;
                end else begin
                    r = req_q[0];
                    chk("mem_we", {31'd0, mem_we}, {31'd0, r.we});
                    chk("mem_addr", mem_addr, r.addr);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, r.be});
                    if (r.chk_wdata) chk("mem_wdata", mem_wdata, r.wdata);
                    mem_ack   = (n == r.wt + 1);
                    mem_rdata = (n == r.wt + 1) ? r.rdata : 32'h0;
                end
            end else begin
                mem_ack = 1'b0;
                if (n > 0) begin
                    if (req_q.size() > 0) begin
                        r = req_q.pop_front();
                        chk("req_len", n, r.len);
                    end
                    n = 0;
                end
            end
        end
    end

    // Output monitor: every result pulse pops one expectation.
    initial begin : monitor
        out_exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid || addr_err || bus_err) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: wb_valid=%b addr_err=%b bus_err=%b expected none",
                             wb_valid, addr_err, bus_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_kind", {29'd0, wb_valid, addr_err, bus_err}, e.kind);
                    if (e.kind == 4) begin
                        chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                        chk("wb_data", wb_data, e.data);
                    end else begin
                        chk("err_addr", err_addr, e.data);
                        if (e.kind == 1) chk("in_ready_after_buserr", {31'd0, in_ready}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_errs", {30'd0, addr_err, bus_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Pass-through ops, back to back
        push_out(4, 1'b1, 5'd3, 32'h0000_00AB); issue(OP_NOP, 32'h0000_00AB, 32'h0, 5'd3);
        push_out(4, 1'b0, 5'd0, 32'h0000_0055); issue(OP_NOP, 32'h0000_0055, 32'h0, 5'd0);
        push_out(4, 1'b1, 5'd5, 32'h0000_1234); issue(4'd7, 32'h0000_1234, 32'h0, 5'd5);
        chk("nop_back_to_back", last_stalls, 0);

        // Stores
        push_req(1'b1, 32'h100, 4'b1000, 32'h8080_8080, 1'b1, 3, 2, 32'h0);
        push_out(4, 1'b0, 5'd0, 32'h0); issue(OP_SB, 32'h103, 32'h0000_0080, 5'd0);
        push_req(1'b1, 32'h104, 4'b1100, 32'hABCD_ABCD, 1'b1, 1, 0, 32'h0);
        push_out(4, 1'b0, 5'd0, 32'h0); issue(OP_SH, 32'h106, 32'h1234_ABCD, 5'd0);
        push_req(1'b1, 32'h108, 4'b1111, 32'hDEAD_BEEF, 1'b1, 2, 1, 32'h0);
        push_out(4, 1'b0, 5'd0, 32'h0); issue(OP_SW, 32'h108, 32'hDEAD_BEEF, 5'd0);
        push_req(1'b1, 32'h10C, 4'b0010, 32'h5A5A_5A5A, 1'b1, 1, 0, 32'h0);
        push_out(4, 1'b0, 5'd0, 32'h0); issue(OP_SB, 32'h10D, 32'hFFFF_FF5A, 5'd0);

        // Loads from 80FF_7F01
        push_req(1'b0, 32'h200, 4'b1111, 32'h0, 1'b0, 1, 0, 32'h80FF_7F01);
        push_out(4, 1'b1, 5'd8, 32'hFFFF_FF80); issue(OP_LB, 32'h203, 32'h0, 5'd8);
        push_req(1'b0, 32'h200, 4'b1111, 32'h0, 1'b0, 2, 1, 32'h80FF_7F01);
        push_out(4, 1'b1, 5'd9, 32'h0000_0080); issue(OP_LBU, 32'h203, 32'h0, 5'd9);
        push_req(1'b0, 32'h200, 4'b1111, 32'h0, 1'b0, 1, 0, 32'h80FF_7F01);
        push_out(4, 1'b1, 5'd10, 32'hFFFF_80FF); issue(OP_LH, 32'h202, 32'h0, 5'd10);
        push_req(1'b0, 32'h200, 4'b1111, 32'h0, 1'b0, 1, 0, 32'h80FF_7F01);
        push_out(4, 1'b1, 5'd11, 32'h0000_7F01); issue(OP_LHU, 32'h200, 32'h0, 5'd11);
        push_req(1'b0, 32'h200, 4'b1111, 32'h0, 1'b0, 3, 2, 32'h80FF_7F01);
        push_out(4, 1'b1, 5'd12, 32'h80FF_7F01); issue(OP_LW, 32'h200, 32'h0, 5'd12);
        push_req(1'b0, 32'h200, 4'b1111, 32'h0, 1'b0, 1, 0, 32'h80FF_7F01);
        push_out(4, 1'b1, 5'd13, 32'h0000_0001); issue(OP_LB, 32'h200, 32'h0, 5'd13);
        push_req(1'b0, 32'h200, 4'b1111, 32'h0, 1'b0, 1, 0, 32'h80FF_7F01);
        push_out(4, 1'b1, 5'd14, 32'h0000_7F01); issue(OP_LH, 32'h200, 32'h0, 5'd14);
        push_req(1'b0, 32'h200, 4'b1111, 32'h0, 1'b0, 1, 0, 32'h80FF_7F01);
        push_out(4, 1'b0, 5'd0, 32'h80FF_7F01); issue(OP_LW, 32'h200, 32'h0, 5'd0);

        // Misaligned accesses: no request, then next op accepted at once
        push_out(2, 1'b0, 5'd0, 32'h102); issue(OP_LW, 32'h102, 32'h0, 5'd4);
        push_out(4, 1'b1, 5'd1, 32'h77); issue(OP_NOP, 32'h77, 32'h0, 5'd1);
        chk("accept_after_misalign", last_stalls, 0);
        push_out(2, 1'b0, 5'd0, 32'h301); issue(OP_LH, 32'h301, 32'h0, 5'd4);
        push_out(2, 1'b0, 5'd0, 32'h305); issue(OP_SH, 32'h305, 32'h0, 5'd0);
        push_out(2, 1'b0, 5'd0, 32'h30A); issue(OP_SW, 32'h30A, 32'h0, 5'd0);

        // Timeout after 4 request cycles, then ack on the last allowed cycle
        push_req(1'b0, 32'h400, 4'b1111, 32'h0, 1'b0, 4, 100, 32'h0);
        push_out(1, 1'b0, 5'd0, 32'h400); issue(OP_LW, 32'h400, 32'h0, 5'd2);
        push_req(1'b0, 32'h404, 4'b1111, 32'h0, 1'b0, 4, 3, 32'h1122_3344);
        push_out(4, 1'b1, 5'd2, 32'h1122_3344); issue(OP_LW, 32'h404, 32'h0, 5'd2);

        // Reset in the middle of an access
        push_req(1'b0, 32'h500, 4'b1111, 32'h0, 1'b0, 2, 100, 32'h0);
        issue(OP_LW, 32'h500, 32'h0, 5'd3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("midrst_errs", {30'd0, addr_err, bus_err}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_out(4, 1'b1, 5'd6, 32'h0000_CAFE); issue(OP_NOP, 32'h0000_CAFE, 32'h0, 5'd6);

        k = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0 || req_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: outputs left=%0d requests left=%0d expected 0", exp_q.size(), req_q.size());
        end
        repeat (6) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
